// File: rtl/conv1d_engine.sv
// Sequencer and MAC datapath for 1-D valid-mode convolution between an input
// memory with registered 1-cycle reads and an output memory; K-tap kernel held in registers.
module conv1d_engine #(
    parameter int WIDTH   = 16,
    parameter int SIZE    = 64,
    parameter int LOGSIZE = 6,
    parameter int K       = 4,
    parameter int LOGK    = 2,
    parameter int FRAC    = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic        [LOGSIZE:0]   n_in,
    input  logic                      coef_wr,
    input  logic        [LOGK-1:0]    coef_addr,
    input  logic signed [WIDTH-1:0]   coef_in,
    output logic        [LOGSIZE-1:0] x_addr,
    input  logic signed [WIDTH-1:0]   x_data,
    output logic        [LOGSIZE-1:0] y_addr,
    output logic signed [WIDTH-1:0]   y_data,
    output logic                      y_wr_en,
    output logic                      busy,
    output logic                      done,
    output logic                      ovf,
    output logic                      len_err
);

    localparam int PW = 2 * WIDTH;
    localparam int AW = 2 * WIDTH + 3;
    localparam logic [LOGSIZE:0] K_N    = (LOGSIZE + 1)'(K);
    localparam logic [LOGSIZE:0] SIZE_N = (LOGSIZE + 1)'(SIZE);
    localparam logic [LOGK-1:0]  T_LAST = LOGK'(K - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                    state;
    logic        [LOGK-1:0]    t;
    logic        [LOGSIZE-1:0] n;
    logic        [LOGSIZE-1:0] n_last;
    logic signed [WIDTH-1:0]   coef [K];
    logic signed [AW-1:0]      acc;

    logic        [LOGK-1:0]    tap;
    logic signed [PW-1:0]      prod;
    logic signed [AW-1:0]      acc_next;
    logic signed [AW-1:0]      shifted;
    logic                      sat_hi;
    logic                      sat_lo;
    logic signed [WIDTH-1:0]   sat_val;
    logic                      len_ok;

    // The sample on x_data belongs to the address issued one cycle earlier, so
    // READ step t pairs it with coef[t-1] and DRAIN with the last tap.
    always_comb begin
        tap      = (state == S_DRAIN) ? T_LAST : t - 1'b1;
        prod     = x_data * coef[tap];
        acc_next = acc + AW'(prod);
        shifted  = acc_next >>> FRAC;
        // Result fits when every bit above the result sign bit matches the sign.
        sat_hi   = !shifted[AW-1] && (shifted[AW-2:WIDTH-1] != '0);
        sat_lo   =  shifted[AW-1] && (~shifted[AW-2:WIDTH-1] != '0);
        if (sat_hi)
            sat_val = {1'b0, {(WIDTH-1){1'b1}}};
        else if (sat_lo)
            sat_val = {1'b1, {(WIDTH-1){1'b0}}};
        else
            sat_val = shifted[WIDTH-1:0];
        len_ok   = (n_in >= K_N) && (n_in <= SIZE_N);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            t       <= '0;
            n       <= '0;
            n_last  <= '0;
            acc     <= '0;
            // NOTE: the kernel is a small register file, not a RAM macro, so it
            // is cleared on reset like any other state.
            for (int i = 0; i < K; i++)
                coef[i] <= '0;
            x_addr  <= '0;
            y_addr  <= '0;
            y_data  <= '0;
            y_wr_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            len_err <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here and are raised only by the
            // state that owns them, which keeps each pulse exactly one cycle.
            y_wr_en <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (coef_wr && (32'(coef_addr) < K))
                        coef[coef_addr] <= coef_in;
                    if (start) begin
                        ovf <= 1'b0;
                        if (len_ok) begin
                            len_err <= 1'b0;
                            busy    <= 1'b1;
                            n       <= '0;
                            n_last  <= LOGSIZE'(n_in - K_N);
                            t       <= '0;
                            x_addr  <= '0;
                            acc     <= '0;
                            state   <= S_READ;
                        end else begin
                            len_err <= 1'b1;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end
                S_READ: begin
                    if (t != '0)
                        acc <= acc_next;
                    if (t == T_LAST) begin
                        x_addr <= '0;
                        state  <= S_DRAIN;
                    end else begin
                        t      <= t + 1'b1;
                        x_addr <= x_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    acc     <= acc_next;
                    y_wr_en <= 1'b1;
                    y_addr  <= n;
                    y_data  <= sat_val;
                    if (sat_hi || sat_lo)
                        ovf <= 1'b1;
                    state   <= S_WRITE;
                end
                S_WRITE: begin
                    acc <= '0;
                    if (n == n_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        n      <= n + 1'b1;
                        t      <= '0;
                        x_addr <= n + 1'b1;
                        state  <= S_READ;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
